// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic bitstream generators:
// FSM state encoding, maximal-length LFSR tap masks and counter sizing.
package stoch_pkg;

    typedef enum logic [0:0] {IDLE, RUN} stoch_state_e;

    // Fibonacci tap masks: bit (t-1) set for polynomial tap t.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    // Bits needed to hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stoch_vec_gen_if.sv
// Load/stream bus of the stochastic vector generator; the generator is the slave.
interface stoch_vec_gen_if #(
    parameter int unsigned VEC_LEN   = 2,
    parameter int unsigned BIT_WIDTH = 8
);
    logic                         load_valid;
    logic                         load_ready;
    logic [VEC_LEN-1:0]           x_sign;
    logic [VEC_LEN*BIT_WIDTH-1:0] x_mag;
    logic [VEC_LEN-1:0]           up;
    logic [VEC_LEN-1:0]           un;
    logic                         out_valid;
    logic                         done;

    modport master (
        output load_valid, x_sign, x_mag,
        input  load_ready, up, un, out_valid, done
    );

    modport slave (
        input  load_valid, x_sign, x_mag,
        output load_ready, up, un, out_valid, done
    );
endinterface

// File: rtl/stoch_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous reset/load to SEED and step enable.
// When load and en coincide, the step is taken from SEED.
module stoch_lfsr import stoch_pkg::*; #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] state
);
    localparam logic [15:0]      TapsFull = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] Taps     = TapsFull[WIDTH-1:0];

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        base = load ? SEED : state;
        nxt  = {base[WIDTH-2:0], ^(base & Taps)};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SEED;
        end else if (en) begin
            state <= nxt;
        end else if (load) begin
            state <= SEED;
        end
    end
endmodule

// File: rtl/stoch_vec_gen.sv
// Signed vector to dual-rail (up/un) stochastic bitstream generator.
// Define STOCH_GEN_RESEED_EN to reload the LFSR with LFSR_SEED on every accepted vector.
module stoch_vec_gen import stoch_pkg::*; #(
    parameter int unsigned VEC_LEN    = 2,
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned STREAM_LEN = 255,
    parameter int unsigned LFSR_SEED  = 1
) (
    input logic            CLK,
    input logic            RST,
    stoch_vec_gen_if.slave bus
);
    localparam int unsigned     CntW    = cnt_width(STREAM_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(STREAM_LEN - 1);

    stoch_state_e                 state_q, state_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [VEC_LEN-1:0]           sign_q, sign_d;
    logic [VEC_LEN*BIT_WIDTH-1:0] mag_q, mag_d;
    logic [VEC_LEN-1:0]           up_q, up_d, un_q, un_d;
    logic                         valid_q, valid_d, done_q, done_d;

    logic [BIT_WIDTH-1:0]         lfsr_state, r_base, rot, mag_sel;
    logic [VEC_LEN-1:0]           src_sign;
    logic [VEC_LEN*BIT_WIDTH-1:0] src_mag;
    logic                         last, accept, produce, hit, lfsr_en, lfsr_load;

    assign last           = (state_q == RUN) && (cnt_q == LastCnt);
    assign bus.load_ready = (state_q == IDLE) || last;
    assign accept         = bus.load_valid && bus.load_ready;
    assign lfsr_en        = accept || ((state_q == RUN) && !last);

`ifdef STOCH_GEN_RESEED_EN
    assign lfsr_load = accept;
`else
    assign lfsr_load = 1'b0;
`endif

    // The bit produced at a reseeding accept compares against the seed itself.
    assign r_base = lfsr_load ? BIT_WIDTH'(LFSR_SEED) : lfsr_state;

    stoch_lfsr #(
        .WIDTH(BIT_WIDTH),
        .SEED (BIT_WIDTH'(LFSR_SEED))
    ) u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .en   (lfsr_en),
        .load (lfsr_load),
        .state(lfsr_state)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        up_d     = '0;
        un_d     = '0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        src_sign = sign_q;
        src_mag  = mag_q;
        produce  = 1'b0;
        rot      = '0;
        mag_sel  = '0;
        hit      = 1'b0;

        if (accept) begin
            state_d  = RUN;
            cnt_d    = '0;
            sign_d   = bus.x_sign;
            mag_d    = bus.x_mag;
            src_sign = bus.x_sign;
            src_mag  = bus.x_mag;
            produce  = 1'b1;
        end else if ((state_q == RUN) && !last) begin
            cnt_d   = cnt_q + CntW'(1);
            produce = 1'b1;
        end else if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (produce) begin
            valid_d = 1'b1;
            done_d  = (cnt_d == LastCnt);
            for (int i = 0; i < int'(VEC_LEN); i++) begin
                // Per-element rotation decorrelates the streams sharing one LFSR.
                rot     = (r_base << (i % BIT_WIDTH)) | (r_base >> (BIT_WIDTH - (i % BIT_WIDTH)));
                mag_sel = src_mag[i*BIT_WIDTH +: BIT_WIDTH];
                hit     = (mag_sel != '0) && (rot <= mag_sel);
                up_d[i] = hit && !src_sign[i];
                un_d[i] = hit && src_sign[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= '0;
            mag_q   <= '0;
            up_q    <= '0;
            un_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            up_q    <= up_d;
            un_q    <= un_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.up        = up_q;
    assign bus.un        = un_q;
    assign bus.out_valid = valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_stoch_vec_gen.sv
// Self-checking bench: sequence-table model checked every cycle plus directed stream tests.
module tb_stoch_vec_gen;
    localparam int VL  = 2;
    localparam int BW  = 8;
    localparam int SL  = 255;
    localparam int SL2 = 100;
    localparam int PER = 255;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    stoch_vec_gen_if #(.VEC_LEN(VL), .BIT_WIDTH(BW)) bus ();
    stoch_vec_gen_if #(.VEC_LEN(VL), .BIT_WIDTH(BW)) bus2 ();

    stoch_vec_gen #(.VEC_LEN(VL), .BIT_WIDTH(BW), .STREAM_LEN(SL), .LFSR_SEED(1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );
    stoch_vec_gen #(.VEC_LEN(VL), .BIT_WIDTH(BW), .STREAM_LEN(SL2), .LFSR_SEED(1)) dut2 (
        .CLK(CLK), .RST(RST), .bus(bus2)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] seq [PER];   // seq[k] = LFSR value k steps after the seed

    int up_cnt [VL];
    int un_cnt [VL];
    int done_cnt, valid_cnt, both_cnt;

    // model state
    bit              m_busy = 1'b0;
    int              m_idx = 0;
    int              m_phase = 0;
    logic [VL-1:0]   m_sign = '0;
    logic [VL*BW-1:0] m_mag = '0;
    logic [VL-1:0]   e_up = '0;
    logic [VL-1:0]   e_un = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
        if (s == 0) return v;
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic hit(input logic [7:0] r, input logic [7:0] m);
        return (m != 8'd0) && (r <= m);
    endfunction

    task automatic emit(input logic [VL-1:0] s, input logic [VL*BW-1:0] mg);
        logic [7:0] r;
        logic [7:0] m;
        for (int e = 0; e < VL; e++) begin
            r = rotl(seq[m_phase], e % BW);
            m = mg[e*BW +: BW];
            e_up[e] = hit(r, m) && !s[e];
            e_un[e] = hit(r, m) && s[e];
        end
        m_phase = (m_phase + 1) % PER;
    endtask

    // Model advances on the same edges the DUT samples.
    initial forever begin
        @(posedge CLK);
        if (RST) begin
            m_busy = 1'b0; m_idx = 0; m_phase = 0; e_up = '0; e_un = '0;
        end else if (bus.load_valid && (!m_busy || m_idx == SL - 1)) begin
`ifdef STOCH_GEN_RESEED_EN
            m_phase = 0;
`endif
            m_sign = bus.x_sign; m_mag = bus.x_mag; m_busy = 1'b1; m_idx = 0;
            emit(m_sign, m_mag);
        end else if (m_busy && m_idx < SL - 1) begin
            m_idx++;
            emit(m_sign, m_mag);
        end else begin
            m_busy = 1'b0; e_up = '0; e_un = '0;
        end
    end

    // Per-cycle compare and stream statistics, sampled on the falling edge.
    initial forever begin
        @(negedge CLK);
        chk("out_valid", bus.out_valid, m_busy);
        chk("done", bus.done, m_busy && m_idx == SL - 1);
        chk("load_ready", bus.load_ready, !m_busy || m_idx == SL - 1);
        chk("up", bus.up, e_up);
        chk("un", bus.un, e_un);
        if (bus.out_valid) begin
            valid_cnt++;
            for (int e = 0; e < VL; e++) begin
                up_cnt[e] += int'(bus.up[e]);
                un_cnt[e] += int'(bus.un[e]);
            end
            if ((bus.up & bus.un) != '0) both_cnt++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clr_counts();
        for (int e = 0; e < VL; e++) begin
            up_cnt[e] = 0; un_cnt[e] = 0;
        end
        done_cnt = 0; valid_cnt = 0; both_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (bus.out_valid && g < 600) begin
            tick();
            g++;
        end
        chk(name, bus.out_valid, 0);
    endtask

    initial begin
        logic [7:0] v;
        bit seen [256];
        int uniq, mism, a_up0, a_up1, a_valid, g;
        logic [VL-1:0] run1_up [100];
        logic [VL-1:0] run1_un [100];
        logic exp_a [SL2];
        logic exp_b [SL2];
        logic got_a [SL2];
        logic got_b [SL2];
        int base2, exp_diff, dut_diff, cnt_a, cnt_b, ecnt_a, ecnt_b, mism_a, mism_b;

        bus.load_valid = 1'b0; bus.x_sign = '0; bus.x_mag = '0;
        bus2.load_valid = 1'b0; bus2.x_sign = '0; bus2.x_mag = '0;
        clr_counts();

        // Build and pin the reference LFSR sequence (x^8+x^4+x^3+x^2+1 recurrence).
        v = 8'h01;
        for (int k = 0; k < PER; k++) begin
            seq[k] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        chk("seq0", seq[0], 8'h01);
        chk("seq1", seq[1], 8'h02);
        chk("seq3", seq[3], 8'h08);
        chk("seq4", seq[4], 8'h11);
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        uniq = 0;
        for (int k = 0; k < PER; k++) begin
            if (!seen[seq[k]]) uniq++;
            seen[seq[k]] = 1'b1;
        end
        chk("seq_period", uniq, 255);
        chk("seq_nonzero", seen[0], 0);

        // Reset then idle
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_ready", bus.load_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_updn", {bus.up, bus.un}, 0);
        RST = 1'b0;
        repeat (2) tick();
        chk("idle_ready", bus.load_ready, 1);

        // +64 / -200 single stream
        clr_counts();
        bus.x_sign = 2'b10; bus.x_mag = {8'd200, 8'd64}; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.x_sign = 2'b01; bus.x_mag = 16'hA5A5;
        chk("t2_first_valid", bus.out_valid, 1);
        wait_idle("t2_end");
        chk("t2_up0", up_cnt[0], 64);
        chk("t2_un0", un_cnt[0], 0);
        chk("t2_un1", un_cnt[1], 200);
        chk("t2_up1", up_cnt[1], 0);
        chk("t2_done", done_cnt, 1);
        chk("t2_valid", valid_cnt, 255);

        // Back-to-back: {+100,+50} then {+255,+0} held at done
        clr_counts();
        bus.x_sign = 2'b00; bus.x_mag = {8'd50, 8'd100}; bus.load_valid = 1'b1;
        tick();
        bus.x_mag = {8'd0, 8'd255};
        g = 0;
        while (!bus.done && g < 600) begin
            tick();
            g++;
        end
        chk("t3_done_seen", bus.done, 1);
        a_up0 = up_cnt[0]; a_up1 = up_cnt[1]; a_valid = valid_cnt;
        tick();
        bus.load_valid = 1'b0;
        chk("t3_no_gap", bus.out_valid, 1);
        wait_idle("t3_end");
        chk("t3_a_up0", a_up0, 100);
        chk("t3_a_up1", a_up1, 50);
        chk("t3_a_valid", a_valid, 255);
        chk("t3_b_up0", up_cnt[0] - a_up0, 255);
        chk("t3_b_up1", up_cnt[1] - a_up1, 0);
        chk("t3_done", done_cnt, 2);
        chk("t3_valid", valid_cnt, 510);

        // Edge magnitudes: -0 and +1
        clr_counts();
        bus.x_sign = 2'b01; bus.x_mag = {8'd1, 8'd0}; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        wait_idle("t4_end");
        chk("t4_up0", up_cnt[0], 0);
        chk("t4_un0", un_cnt[0], 0);
        chk("t4_up1", up_cnt[1], 1);
        chk("t4_un1", un_cnt[1], 0);
        chk("t4_both", both_cnt, 0);

        // Reset mid-stream, then replay
        clr_counts();
        bus.x_sign = 2'b10; bus.x_mag = {8'd200, 8'd64}; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            run1_up[k] = bus.up; run1_un[k] = bus.un;
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t5_valid_rst", bus.out_valid, 0);
        chk("t5_ready_rst", bus.load_ready, 1);
        repeat (2) tick();
        chk("t5_no_done", done_cnt, 0);
        clr_counts();
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        mism = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.up !== run1_up[k] || bus.un !== run1_un[k]) mism++;
            tick();
        end
        chk("t5_replay", mism, 0);
        wait_idle("t5_end");
        chk("t5_up0", up_cnt[0], 64);
        chk("t5_un1", un_cnt[1], 200);

        // Short-stream instance: two loads of +128, with an idle gap
`ifdef STOCH_GEN_RESEED_EN
        base2 = 0;
`else
        base2 = SL2;
`endif
        ecnt_a = 0; ecnt_b = 0; exp_diff = 0;
        for (int p = 0; p < SL2; p++) begin
            exp_a[p] = hit(seq[p], 8'd128);
            exp_b[p] = hit(seq[(base2 + p) % PER], 8'd128);
            ecnt_a += int'(exp_a[p]);
            ecnt_b += int'(exp_b[p]);
            if (exp_a[p] != exp_b[p]) exp_diff++;
        end
        bus2.x_sign = 2'b00; bus2.x_mag = {8'd128, 8'd128}; bus2.load_valid = 1'b1;
        tick();
        bus2.load_valid = 1'b0;
        for (int p = 0; p < SL2; p++) begin
            got_a[p] = bus2.up[0];
            tick();
        end
        chk("t6_idle_a", bus2.out_valid, 0);
        tick();
        bus2.load_valid = 1'b1;
        tick();
        bus2.load_valid = 1'b0;
        for (int p = 0; p < SL2; p++) begin
            got_b[p] = bus2.up[0];
            tick();
        end
        chk("t6_idle_b", bus2.out_valid, 0);
        cnt_a = 0; cnt_b = 0; dut_diff = 0; mism_a = 0; mism_b = 0;
        for (int p = 0; p < SL2; p++) begin
            cnt_a += int'(got_a[p]);
            cnt_b += int'(got_b[p]);
            if (got_a[p] !== got_b[p]) dut_diff++;
            if (got_a[p] !== exp_a[p]) mism_a++;
            if (got_b[p] !== exp_b[p]) mism_b++;
        end
        chk("t6_bits_a", mism_a, 0);
        chk("t6_bits_b", mism_b, 0);
        chk("t6_sum", cnt_a + cnt_b, ecnt_a + ecnt_b);
        chk("t6_diff", dut_diff, exp_diff);
`ifdef STOCH_GEN_RESEED_EN
        chk("t6_same", dut_diff != 0, 0);
`else
        chk("t6_differ", dut_diff != 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
